// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one i2c_master between N_REQ register-access clients.
// Sequences the master's en/busy handshake and returns read data / error to the granted client.
module i2c_req_arbiter #(
    parameter int N_REQ    = 4,
    parameter int START_TO = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*7-1:0] req_addr,
    input  logic [N_REQ-1:0]   req_rw,
    input  logic [N_REQ*5-1:0] req_mem,
    input  logic [N_REQ*8-1:0] req_wdata,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [7:0]         rsp_rdata,
    output logic               rsp_err,
    output logic [2:0]         grant_id,
    output logic               ctl_busy,
    output logic               m_en,
    output logic [6:0]         m_addr,
    output logic               m_rw,
    output logic [4:0]         m_mem_addr,
    output logic [7:0]         m_data_wr,
    input  logic [7:0]         m_data_rd,
    input  logic               m_ack_err,
    input  logic               m_busy
);

    localparam int CNT_W = (START_TO < 1) ? 1 : $clog2(START_TO + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LAUNCH    = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_RESP      = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;

    logic [7:0]       w_valid_pad;
    logic [3:0]       w_idx;
    logic [2:0]       w_win;
    logic             w_found;
    logic [N_REQ-1:0] w_grant_oh;
    logic [N_REQ-1:0] w_rsp_oh;

    // Scan from the highest offset down so the requester closest to r_ptr wins last.
    // NOTE: every always_comb output gets a default first, so no path leaves a latch.
    always_comb begin
        w_valid_pad = 8'(req_valid);
        w_found     = 1'b0;
        w_win       = r_ptr;
        w_idx       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_ptr} + 4'(k);
            if (w_idx >= 4'(N_REQ)) begin
                w_idx = w_idx - 4'(N_REQ);
            end
            if (w_valid_pad[w_idx[2:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[2:0];
            end
        end
    end

    assign w_grant_oh = N_REQ'(1) << w_win;
    assign w_rsp_oh   = N_REQ'(1) << grant_id;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_cnt      <= '0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            grant_id   <= '0;
            ctl_busy   <= 1'b0;
            m_en       <= 1'b0;
            m_addr     <= '0;
            m_rw       <= 1'b0;
            m_mem_addr <= '0;
            m_data_wr  <= '0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            m_en      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found && !m_busy) begin
                        m_addr     <= req_addr[7*int'(w_win) +: 7];
                        m_rw       <= req_rw[w_win];
                        m_mem_addr <= req_mem[5*int'(w_win) +: 5];
                        m_data_wr  <= req_wdata[8*int'(w_win) +: 8];
                        grant_id   <= w_win;
                        req_ready  <= w_grant_oh;
                        r_ptr      <= (w_win == 3'(N_REQ - 1)) ? 3'd0 : w_win + 3'd1;
                        ctl_busy   <= 1'b1;
                        r_state    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    m_en    <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (m_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_cnt == CNT_W'(START_TO)) begin
                        // Master never started: answer with an error instead of hanging.
                        rsp_valid <= w_rsp_oh;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        r_state   <= S_RESP;
                    end
                end
                S_WAIT_DONE: begin
                    if (!m_busy) begin
                        rsp_valid <= w_rsp_oh;
                        rsp_rdata <= m_data_rd;
                        rsp_err   <= m_ack_err;
                        r_state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    ctl_busy <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    ctl_busy <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Randomized and directed bench for i2c_req_arbiter with a behavioural i2c_master/slave model
// and a transaction-level reference for grant order, timing and response contents.
module tb_i2c_req_arbiter;
    localparam int N        = 4;
    localparam int START_TO = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*7-1:0] req_addr  = '0;
    logic [N-1:0]   req_rw    = '0;
    logic [N*5-1:0] req_mem   = '0;
    logic [N*8-1:0] req_wdata = '0;
    logic [N-1:0]   req_ready, rsp_valid;
    logic [7:0]     rsp_rdata;
    logic           rsp_err;
    logic [2:0]     grant_id;
    logic           ctl_busy, m_en, m_rw;
    logic [6:0]     m_addr;
    logic [4:0]     m_mem_addr;
    logic [7:0]     m_data_wr;
    logic [7:0]     m_data_rd = '0;
    logic           m_ack_err = 1'b0;
    logic           m_busy    = 1'b0;

    always #5 clk = ~clk;

    i2c_req_arbiter #(.N_REQ(N), .START_TO(START_TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_rw(req_rw),
        .req_mem(req_mem), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .grant_id(grant_id), .ctl_busy(ctl_busy),
        .m_en(m_en), .m_addr(m_addr), .m_rw(m_rw), .m_mem_addr(m_mem_addr),
        .m_data_wr(m_data_wr), .m_data_rd(m_data_rd), .m_ack_err(m_ack_err),
        .m_busy(m_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Client request fields
    logic [6:0] c_addr [N];
    logic       c_rw   [N];
    logic [4:0] c_mem  [N];
    logic [7:0] c_wd   [N];
    bit         persist[N];

    // Reference model state
    int         cyc = 0;
    int         ptr_m = 0;
    bit         mbusy = 0;
    int         elig_from = 1 << 30;
    bit         ex_pend = 0;
    int         ex_id = 0;
    logic [6:0] ex_addr;
    logic       ex_rw;
    logic [4:0] ex_mem;
    logic [7:0] ex_wd;
    logic [7:0] ex_rdata;
    logic       ex_err;
    int         en_cyc_exp = -1;
    int         exp_rsp_cyc = -1;
    logic [7:0] held_r = '0;
    logic       held_e = 1'b0;
    int         held_gid = 0;
    int         grant_log[$];
    logic [N-1:0] arb_valid = '0;
    logic [7:0] ref_mem   [8][32];
    logic [7:0] slave_mem [8][32];

    // Master/slave behavioural model
    bit         tie_low = 0;
    int         mphase = 0;
    int         mlat = 0;
    int         mlen = 0;
    logic [6:0] ma;
    logic       mrw;
    logic [4:0] mm;
    logic [7:0] mwd;

    function automatic bit exists(input logic [6:0] a);
        return (a >= 7'd1) && (a <= 7'd4);
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_fields();
        for (int i = 0; i < N; i++) begin
            req_addr[i*7 +: 7]  = c_addr[i];
            req_rw[i]           = c_rw[i];
            req_mem[i*5 +: 5]   = c_mem[i];
            req_wdata[i*8 +: 8] = c_wd[i];
        end
    endtask

    task automatic post(input int i, input logic [6:0] a, input logic rw,
                        input logic [4:0] m, input logic [7:0] d);
        c_addr[i] = a; c_rw[i] = rw; c_mem[i] = m; c_wd[i] = d;
        drive_fields();
        req_valid[i] = 1'b1;
    endtask

    task automatic monitor();
        int w;
        logic [N-1:0] exp_rv;
        if (!rst && !mbusy && cyc >= elig_from) begin
            w = rr_pick(arb_valid, ptr_m);
            check("grant_ready", 32'(req_ready), (w < 0) ? 0 : (1 << w));
            if (w >= 0) begin
                grant_log.push_back(int'(grant_id));
                ptr_m = (w + 1) % N; mbusy = 1; held_gid = w;
                ex_pend = 1; ex_id = w; en_cyc_exp = cyc + 1;
                ex_addr = c_addr[w]; ex_rw = c_rw[w]; ex_mem = c_mem[w]; ex_wd = c_wd[w];
                ex_rdata = 8'h00; ex_err = 1'b1;
                if (!tie_low && exists(ex_addr)) begin
                    ex_err = 1'b0;
                    if (ex_rw) ref_mem[ex_addr[2:0]][ex_mem] = ex_wd;
                    else       ex_rdata = ref_mem[ex_addr[2:0]][ex_mem];
                end
            end
        end else begin
            check("no_ready", 32'(req_ready), 0);
        end
        check("grant_id", 32'(grant_id), held_gid);
        check("ctl_busy", 32'(ctl_busy), 32'(mbusy));
        check("m_en", 32'(m_en), 32'(cyc == en_cyc_exp));
        if (cyc == en_cyc_exp && tie_low) exp_rsp_cyc = cyc + START_TO + 1;
        if (ex_pend) begin
            check("m_addr", 32'(m_addr), 32'(ex_addr));
            check("m_rw", 32'(m_rw), 32'(ex_rw));
            check("m_mem_addr", 32'(m_mem_addr), 32'(ex_mem));
            check("m_data_wr", 32'(m_data_wr), 32'(ex_wd));
        end
        exp_rv = (cyc == exp_rsp_cyc) ? N'(1 << ex_id) : '0;
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (cyc == exp_rsp_cyc) begin
            held_r = ex_rdata; held_e = ex_err;
            ex_pend = 0; mbusy = 0; elig_from = cyc + 2; exp_rsp_cyc = -1;
        end
        check("rsp_rdata", 32'(rsp_rdata), 32'(held_r));
        check("rsp_err", 32'(rsp_err), 32'(held_e));
    endtask

    task automatic master_step();
        if (mphase == 2) begin
            mlen--;
            if (mlen == 0) begin
                if (exists(ma)) begin
                    if (mrw) slave_mem[ma[2:0]][mm] = mwd;
                    m_data_rd = mrw ? 8'h00 : slave_mem[ma[2:0]][mm];
                    m_ack_err = 1'b0;
                end else begin
                    m_data_rd = 8'h00;
                    m_ack_err = 1'b1;
                end
                m_busy = 1'b0; mphase = 0; exp_rsp_cyc = cyc + 1;
            end
        end
        if (mphase == 0 && m_en && !tie_low) begin
            ma = m_addr; mrw = m_rw; mm = m_mem_addr; mwd = m_data_wr;
            mlat = $urandom_range(0, 2); mlen = $urandom_range(1, 4); mphase = 1;
        end
        if (mphase == 1) begin
            if (mlat == 0) begin m_busy = 1'b1; mphase = 2; end
            else mlat--;
        end
    endtask

    task automatic tick();
        arb_valid = req_valid;
        @(negedge clk);
        cyc++;
        monitor();
        master_step();
        for (int i = 0; i < N; i++) if (req_ready[i] && !persist[i]) req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while ((req_valid != '0 || mbusy || ex_pend) && t < budget) begin
            tick(); t++;
        end
        check("drain_in_budget", 32'(t < budget), 1);
    endtask

    task automatic reset_assert();
        #2 rst = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_m_en", 32'(m_en), 0);
        check("rst_ctl_busy", 32'(ctl_busy), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_m_addr", 32'(m_addr), 0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 0);
        ptr_m = 0; mbusy = 0; ex_pend = 0; en_cyc_exp = -1; exp_rsp_cyc = -1;
        held_r = '0; held_e = 1'b0; held_gid = 0; elig_from = 1 << 30;
        mphase = 0; m_busy = 1'b0; m_ack_err = 1'b0; m_data_rd = '0;
        tick(); tick();
    endtask

    task automatic reset_release();
        #2 rst = 1'b0;
        elig_from = cyc + 1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s, t, found;
        for (int a = 0; a < 8; a++)
            for (int m = 0; m < 32; m++) begin ref_mem[a][m] = '0; slave_mem[a][m] = '0; end
        for (int i = 0; i < N; i++) begin
            c_addr[i] = '0; c_rw[i] = 1'b0; c_mem[i] = '0; c_wd[i] = '0; persist[i] = 0;
        end

        reset_assert();
        reset_release();

        // Single write then read back
        post(0, 7'd1, 1'b1, 5'd3, 8'h33);
        wait_idle(50);
        post(0, 7'd1, 1'b0, 5'd3, 8'h00);
        wait_idle(50);
        check("t1_rdata", 32'(rsp_rdata), 32'h33);
        check("t1_err", 32'(rsp_err), 0);

        // Contention from reset, then rotation-dependent ordering
        reset_assert();
        for (int i = 0; i < N; i++) post(i, 7'(i + 1), 1'b1, 5'(i), 8'(8'hA0 + i));
        reset_release();
        s = grant_log.size();
        wait_idle(200);
        check("t2_count", 32'(grant_log.size() - s), 4);
        for (int k = 0; k < 4; k++) check("t2_order", 32'(grant_log[s + k]), 32'(k));
        s = grant_log.size();
        post(1, 7'd2, 1'b0, 5'd1, 8'h00);
        post(3, 7'd4, 1'b0, 5'd3, 8'h00);
        wait_idle(100);
        check("t2_after3_first", 32'(grant_log[s]), 1);
        check("t2_after3_second", 32'(grant_log[s + 1]), 3);
        post(2, 7'd3, 1'b0, 5'd2, 8'h00);
        wait_idle(50);
        s = grant_log.size();
        post(1, 7'd2, 1'b0, 5'd1, 8'h00);
        post(3, 7'd4, 1'b0, 5'd3, 8'h00);
        wait_idle(100);
        check("t2_after2_first", 32'(grant_log[s]), 3);
        check("t2_after2_second", 32'(grant_log[s + 1]), 1);

        // NACK, a request withdrawn before arbitration, then a good access
        post(2, 7'h05, 1'b1, 5'd0, 8'h11);
        t = 0;
        while (!mbusy && t < 20) begin tick(); t++; end
        req_valid[1] = 1'b1;
        tick(); tick();
        req_valid[1] = 1'b0;
        wait_idle(50);
        check("t3_nack_err", 32'(rsp_err), 1);
        post(2, 7'h02, 1'b0, 5'd1, 8'h00);
        wait_idle(50);
        check("t3_ok_err", 32'(rsp_err), 0);

        // Start timeout with m_busy held low
        tie_low = 1;
        post(1, 7'd3, 1'b0, 5'd4, 8'h00);
        wait_idle(80);
        check("t4_to_err", 32'(rsp_err), 1);
        tie_low = 0;
        post(1, 7'd3, 1'b1, 5'd4, 8'h5A);
        wait_idle(50);
        check("t4_recover_err", 32'(rsp_err), 0);

        // Reset while waiting for the master to finish
        post(2, 7'd3, 1'b0, 5'd7, 8'h00);
        t = 0;
        while (!mbusy && t < 20) begin tick(); t++; end
        post(3, 7'd4, 1'b1, 5'd9, 8'hC3);
        post(1, 7'd2, 1'b1, 5'd9, 8'h3C);
        t = 0;
        while (mphase != 2 && t < 20) begin tick(); t++; end
        mlen = 4;
        tick();
        check("t5_in_flight", 32'(ctl_busy), 1);
        reset_assert();
        s = grant_log.size();
        reset_release();
        wait_idle(100);
        check("t5_first", 32'(grant_log[s]), 1);
        check("t5_second", 32'(grant_log[s + 1]), 3);

        // Persistent client 0 must not starve client 3
        persist[0] = 1;
        post(0, 7'd2, 1'b1, 5'd5, 8'h77);
        post(3, 7'd4, 1'b0, 5'd5, 8'h00);
        s = grant_log.size();
        found = -1; t = 0;
        while (found < 0 && t < 300) begin
            tick(); t++;
            for (int k = s; k < grant_log.size(); k++)
                if (grant_log[k] == 3 && found < 0) found = k - s + 1;
        end
        check("t6_no_starve", 32'(found > 0 && found <= N), 1);
        persist[0] = 0;
        wait_idle(100);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 7) == 0)
                    post(i, 7'($urandom_range(1, 6)), 1'($urandom_range(0, 1)),
                         5'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            end
            tick();
        end
        wait_idle(400);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
